// File: rtl/regs_pkg.sv
// Shared types and constants for the register file and its write-port driver.
package regs_pkg;

  localparam int unsigned REGS_WIDTH_DFLT      = 8;
  localparam int unsigned REGS_WIDTH_ADDR_DFLT = 4;
  localparam int unsigned REGS_DEPTH           = 1 << REGS_WIDTH_ADDR_DFLT;

  localparam logic [REGS_WIDTH_DFLT-1:0] REGS_ZERO_WORD = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DONE  = 2'd3
  } regs_state_e;

  function automatic int unsigned regs_depth(input int unsigned aw);
    return 32'(1) << aw;
  endfunction

endpackage

// File: rtl/regs.sv
// Register file: one synchronous write port, one combinational read port.
module regs
  import regs_pkg::*;
#(
  parameter int unsigned REGS_WIDTH      = REGS_WIDTH_DFLT,
  parameter int unsigned REGS_WIDTH_ADDR = REGS_WIDTH_ADDR_DFLT
) (
  input  logic                       i_clk,
  input  logic                       i_wt_en,
  input  logic [REGS_WIDTH-1:0]      i_data,
  input  logic [REGS_WIDTH_ADDR-1:0] i_data_addr,
  input  logic [REGS_WIDTH_ADDR-1:0] i_rd_addr,
  output logic [REGS_WIDTH-1:0]      o_rd_data_c
);

  localparam int unsigned DEPTH = regs_depth(REGS_WIDTH_ADDR);

  logic [REGS_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wt_en) begin
      r_mem[i_data_addr] <= i_data;
    end
  end

  assign o_rd_data_c = r_mem[i_rd_addr];

endmodule

// File: rtl/regs_fill.sv
// Write-port driver for regs: zero-fills the whole file on a clear, or streams
// valid/ready words into consecutive (wrapping) addresses from a base.
module regs_fill
  import regs_pkg::*;
#(
  parameter int unsigned REGS_WIDTH      = REGS_WIDTH_DFLT,
  parameter int unsigned REGS_WIDTH_ADDR = REGS_WIDTH_ADDR_DFLT
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_clr,
  input  logic                       i_load,
  input  logic [REGS_WIDTH_ADDR-1:0] i_load_base,
  input  logic [REGS_WIDTH_ADDR:0]   i_load_len,
  input  logic                       i_valid,
  input  logic [REGS_WIDTH-1:0]      i_data,
  output logic                       o_ready,
  output logic                       o_wt_en,
  output logic [REGS_WIDTH-1:0]      o_wt_data,
  output logic [REGS_WIDTH_ADDR-1:0] o_wt_addr,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int unsigned LEN_W = REGS_WIDTH_ADDR + 1;
  localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(regs_depth(REGS_WIDTH_ADDR));
  localparam logic [REGS_WIDTH_ADDR-1:0] LAST_ADDR = '1;

  regs_state_e                r_state;
  logic [REGS_WIDTH_ADDR-1:0] r_addr;
  logic [LEN_W-1:0]           r_remain;
  logic                       r_wt_en;
  logic [REGS_WIDTH-1:0]      r_wt_data;
  logic [REGS_WIDTH_ADDR-1:0] r_wt_addr;
  logic [LEN_W-1:0]           w_len;

  // Lengths beyond the file depth would rewrite entries; cap at one full pass.
  assign w_len = (i_load_len > DEPTH_LEN) ? DEPTH_LEN : i_load_len;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_remain  <= '0;
      r_wt_en   <= 1'b0;
      r_wt_data <= '0;
      r_wt_addr <= '0;
    end else begin
      r_wt_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_clr) begin
            r_state <= ST_CLEAR;
            r_addr  <= '0;
          end else if (i_load) begin
            r_addr   <= i_load_base;
            r_remain <= w_len;
            r_state  <= (w_len == '0) ? ST_DONE : ST_LOAD;
          end
        end
        ST_CLEAR: begin
          r_wt_en   <= 1'b1;
          r_wt_data <= '0;
          r_wt_addr <= r_addr;
          r_addr    <= r_addr + REGS_WIDTH_ADDR'(1);
          if (r_addr == LAST_ADDR) begin
            r_state <= ST_DONE;
          end
        end
        ST_LOAD: begin
          if (i_valid) begin
            r_wt_en   <= 1'b1;
            r_wt_data <= i_data;
            r_wt_addr <= r_addr;
            r_addr    <= r_addr + REGS_WIDTH_ADDR'(1);
            r_remain  <= r_remain - LEN_W'(1);
            if (r_remain == LEN_W'(1)) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_wt_en   = r_wt_en;
  assign o_wt_data = r_wt_data;
  assign o_wt_addr = r_wt_addr;
  assign o_busy    = (r_state != ST_IDLE);
  assign o_ready   = (r_state == ST_LOAD);
  assign o_done    = (r_state == ST_DONE);

endmodule

// File: tb/tb_regs_fill.sv
// Bench for regs_fill driving regs; checks write traffic and file contents.
module tb_regs_fill;
  import regs_pkg::*;

  logic       clk = 1'b0;
  logic       i_rst, i_clr, i_load, i_valid;
  logic [3:0] i_load_base, rd_addr;
  logic [4:0] i_load_len;
  logic [7:0] i_data, rd_data;
  logic       o_ready, o_wt_en, o_busy, o_done;
  logic [7:0] o_wt_data;
  logic [3:0] o_wt_addr;

  always #5 clk = ~clk;

  regs_fill #(.REGS_WIDTH(8), .REGS_WIDTH_ADDR(4)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_clr(i_clr), .i_load(i_load),
    .i_load_base(i_load_base), .i_load_len(i_load_len), .i_valid(i_valid),
    .i_data(i_data), .o_ready(o_ready), .o_wt_en(o_wt_en), .o_wt_data(o_wt_data),
    .o_wt_addr(o_wt_addr), .o_busy(o_busy), .o_done(o_done)
  );

  regs #(.REGS_WIDTH(8), .REGS_WIDTH_ADDR(4)) u_regs (
    .i_clk(clk), .i_wt_en(o_wt_en), .i_data(o_wt_data), .i_data_addr(o_wt_addr),
    .i_rd_addr(rd_addr), .o_rd_data_c(rd_data)
  );

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  typedef struct {
    bit         clr;
    bit         load;
    logic [3:0] base;
    logic [4:0] len;
    int         exp_wr;
    logic [3:0] exp_a0;
    string      nm;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] data_arr  [16];
  logic [7:0] mem_model [REGS_DEPTH];

  // Write/done log gathered on the falling edge.
  wr_t  act_q[$];
  int   cyc = 0;
  int   done_cnt, done_cyc, first_wr_cyc, last_wr_cyc, first_busy_cyc, busy_after_done;
  bit   busy_seen, prev_done;

  always @(negedge clk) begin
    cyc++;
    if (o_wt_en) begin
      if (act_q.size() == 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      act_q.push_back({o_wt_addr, o_wt_data});
    end
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (o_busy && !busy_seen) begin
      busy_seen      = 1'b1;
      first_busy_cyc = cyc;
    end
    if (prev_done && o_busy) busy_after_done++;
    prev_done = o_done;
  end

  task automatic clear_logs();
    act_q.delete();
    done_cnt = 0; done_cyc = -1; first_wr_cyc = -1; last_wr_cyc = -1;
    first_busy_cyc = -1; busy_after_done = 0; busy_seen = 1'b0; prev_done = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic readback(input string nm);
    for (int a = 0; a < REGS_DEPTH; a++) begin
      rd_addr = 4'(a);
      #1;
      chk($sformatf("%s rd[%0d]", nm, a), 32'(rd_data), 32'(mem_model[a]));
    end
  endtask

  // mode: 0 random stalls, 1 no stalls, 2 two stall cycles before beat index 2
  task automatic run_op(input bit clr, input bit load, input logic [3:0] base,
                        input logic [4:0] len, input int mode, input int exp_wr,
                        input logic [3:0] exp_a0, input string nm);
    wr_t exp_q[$];
    int  n_wr, n_beats, beat, stalls;
    bit  seen, ok, valid;
    n_wr    = clr ? REGS_DEPTH : (!load ? 0 : ((int'(len) > REGS_DEPTH) ? REGS_DEPTH : int'(len)));
    n_beats = clr ? 0 : n_wr;
    for (int i = 0; i < n_wr; i++) begin
      if (clr) exp_q.push_back({4'(i), REGS_ZERO_WORD});
      else     exp_q.push_back({4'(int'(base) + i), data_arr[i]});
    end

    @(negedge clk);
    i_clr = clr; i_load = load; i_load_base = base; i_load_len = len; i_valid = 1'b0;
    @(posedge clk);
    clear_logs();
    beat = 0; stalls = 0; seen = 1'b0; ok = 1'b0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (o_busy) seen = 1'b1;
      if (seen && !o_busy) begin
        ok = 1'b1;
        break;
      end
      // Requests raised while busy must be ignored.
      i_clr       = o_busy && ($urandom_range(0, 5) == 0);
      i_load      = o_busy && ($urandom_range(0, 2) == 0);
      i_load_base = 4'($urandom);
      i_load_len  = 5'($urandom_range(0, 20));
      if (beat >= n_beats)                                   valid = 1'($urandom);
      else if (mode == 2 && beat == 2 && stalls < 2 && o_ready) begin
        valid = 1'b0;
        stalls++;
      end
      else if (mode == 0)                                    valid = ($urandom_range(0, 3) != 0);
      else                                                   valid = 1'b1;
      i_valid = valid;
      i_data  = (beat < n_beats) ? data_arr[beat] : 8'($urandom);
      if (o_ready && valid) beat++;
    end
    i_clr = 1'b0; i_load = 1'b0; i_valid = 1'b0;
    #1;
    chk({nm, " completes"}, 32'(ok), 32'd1);
    chk({nm, " write count"}, 32'(act_q.size()), 32'(exp_wr));
    chk({nm, " model count"}, 32'(act_q.size()), 32'(n_wr));
    if (exp_wr > 0 && act_q.size() > 0) chk({nm, " first addr"}, 32'(act_q[0].a), 32'(exp_a0));
    for (int i = 0; i < n_wr && i < act_q.size(); i++) begin
      chk($sformatf("%s wr%0d addr", nm, i), 32'(act_q[i].a), 32'(exp_q[i].a));
      chk($sformatf("%s wr%0d data", nm, i), 32'(act_q[i].d), 32'(exp_q[i].d));
    end
    chk({nm, " done count"}, 32'(done_cnt), 32'd1);
    if (n_wr > 0) chk({nm, " done with last write"}, 32'(done_cyc), 32'(last_wr_cyc));
    else          chk({nm, " done right after request"}, 32'(done_cyc), 32'(first_busy_cyc));
    chk({nm, " busy drops after done"}, 32'(busy_after_done), 32'd0);
    if (clr) begin
      chk({nm, " clear consecutive"}, 32'(last_wr_cyc - first_wr_cyc), 32'd15);
      chk({nm, " clear start"}, 32'(first_wr_cyc), 32'(first_busy_cyc + 1));
    end
    if (mode == 2) chk({nm, " stall span"}, 32'(last_wr_cyc - first_wr_cyc), 32'd5);
    foreach (exp_q[i]) mem_model[exp_q[i].a] = exp_q[i].d;
    readback(nm);
  endtask

  vec_t vecs [8];
  logic [7:0] d0, d1;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 4'd0,  5'd0,  16, 4'd0,  "clear"};
    vecs[1] = '{1'b0, 1'b1, 4'd14, 5'd4,   4, 4'd14, "wrap"};
    vecs[2] = '{1'b0, 1'b1, 4'd6,  5'd0,   0, 4'd0,  "len0"};
    vecs[3] = '{1'b0, 1'b1, 4'd5,  5'd16, 16, 4'd5,  "full"};
    vecs[4] = '{1'b1, 1'b1, 4'd9,  5'd3,  16, 4'd0,  "clr_prio"};
    vecs[5] = '{1'b0, 1'b1, 4'd9,  5'd20, 16, 4'd9,  "clamp"};
    vecs[6] = '{1'b0, 1'b1, 4'd7,  5'd9,   9, 4'd7,  "load9"};
    vecs[7] = '{1'b1, 1'b0, 4'd3,  5'd7,  16, 4'd0,  "clear2"};

    i_rst = 1'b1; i_clr = 1'b0; i_load = 1'b0; i_valid = 1'b0;
    i_load_base = '0; i_load_len = '0; i_data = '0; rd_addr = '0;
    clear_logs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset wt_en", 32'(o_wt_en), 32'd0);
    chk("reset busy",  32'(o_busy),  32'd0);
    chk("reset ready", 32'(o_ready), 32'd0);
    chk("reset done",  32'(o_done),  32'd0);
    chk("reset addr/data", 32'({o_wt_addr, o_wt_data}), 32'd0);
    i_rst = 1'b0;

    foreach (vecs[v]) begin
      for (int i = 0; i < 16; i++) data_arr[i] = 8'($urandom);
      run_op(vecs[v].clr, vecs[v].load, vecs[v].base, vecs[v].len, 0,
             vecs[v].exp_wr, vecs[v].exp_a0, vecs[v].nm);
    end

    data_arr[0] = 8'hA1; data_arr[1] = 8'hB2; data_arr[2] = 8'hC3; data_arr[3] = 8'hD4;
    run_op(1'b0, 1'b1, 4'd3, 5'd4, 2, 4, 4'd3, "stall");

    data_arr[0] = 8'h11; data_arr[1] = 8'h22; data_arr[2] = 8'h33; data_arr[3] = 8'h44;
    run_op(1'b0, 1'b1, 4'd14, 5'd4, 1, 4, 4'd14, "wrap_fixed");

    // Reset after two of five beats.
    d0 = 8'h5A; d1 = 8'hC6;
    @(negedge clk);
    i_load = 1'b1; i_load_base = 4'd0; i_load_len = 5'd5;
    @(posedge clk);
    clear_logs();
    @(negedge clk);
    chk("rst_mid ready", 32'(o_ready), 32'd1);
    i_load = 1'b0; i_valid = 1'b1; i_data = d0;
    @(negedge clk);
    i_data = d1;
    @(negedge clk);
    i_rst = 1'b1; i_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid wt_en", 32'(o_wt_en), 32'd0);
    chk("rst_mid busy",  32'(o_busy),  32'd0);
    chk("rst_mid ready", 32'(o_ready), 32'd0);
    i_rst = 1'b0;
    #1;
    chk("rst_mid no done", 32'(done_cnt), 32'd0);
    chk("rst_mid writes", 32'(act_q.size()), 32'd2);
    mem_model[0] = d0; mem_model[1] = d1;
    readback("rst_mid");

    for (int i = 0; i < 16; i++) data_arr[i] = 8'($urandom);
    run_op(1'b0, 1'b1, 4'd8, 5'd3, 0, 3, 4'd8, "after_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/regs_fill.md
Name: regs_fill

Overview:
- Upstream write-port driver for the `regs` register file.
- Converts two kinds of request into a sequence of single-cycle register-file writes, one write per clock:
  - a "clear" command, which zero-fills every entry;
  - a valid/ready data stream, which is written to consecutive addresses from a base.
- Outputs connect directly to the register file's `i_wt_en`, `i_data` and `i_data_addr` inputs.

Parameters:
- `REGS_WIDTH`, 8: data word width; must match the register file.
- `REGS_WIDTH_ADDR`, 4: address width; the register file depth is 2^`REGS_WIDTH_ADDR`.

Ports:
- `i_clk` input 1: single clock; all logic on the rising edge.
- `i_rst` input 1: synchronous, active-high reset.
- `i_clr` input 1: clear request; sampled only in IDLE.
- `i_load` input 1: stream-load request; sampled only in IDLE.
- `i_load_base` input `REGS_WIDTH_ADDR`: first write address of the load; sampled with `i_load`.
- `i_load_len` input `REGS_WIDTH_ADDR`+1: number of words to load, 0..2^`REGS_WIDTH_ADDR`; sampled with `i_load`.
- `i_valid` input 1: stream word valid.
- `i_data` input `REGS_WIDTH`: stream word.
- `o_ready` output 1: block accepts a stream word this cycle.
- `o_wt_en` output 1: register-file write enable.
- `o_wt_data` output `REGS_WIDTH`: register-file write data.
- `o_wt_addr` output `REGS_WIDTH_ADDR`: register-file write address.
- `o_busy` output 1: state is not IDLE.
- `o_done` output 1: one-cycle completion pulse.

Behaviour:
- Reset values: state IDLE, and `o_ready`, `o_wt_en`, `o_wt_data`, `o_wt_addr`, `o_busy`, `o_done` all 0.
- Reset taken mid-operation: return to IDLE on the next edge with `o_wt_en`=0. Writes already issued stand. There is no `o_done` pulse.
- States: IDLE, CLEAR, LOAD, DONE.
- Write outputs are registered. Decode logic only: `o_busy`=(state!=IDLE), `o_ready`=(state==LOAD), `o_done`=(state==DONE).
- IDLE transitions:
  - `i_clr`=1: go to CLEAR, address counter = 0.
  - Else `i_load`=1 with `i_load_len`=0: go to DONE directly; no writes are issued.
  - Else `i_load`=1: go to LOAD, addr = `i_load_base`, remaining = `i_load_len`.
  - `i_clr` has priority over `i_load` when both are high.
- Requests raised while busy are ignored, not queued.
- CLEAR:
  - Each edge registers `o_wt_en`=1, `o_wt_data`=0, `o_wt_addr`=counter, then increments the counter.
  - After the edge that registers address 2^N-1, go to DONE.
  - A clear therefore issues exactly 2^N writes in consecutive cycles.
- LOAD:
  - A beat is accepted when `i_valid` && `o_ready`.
  - Each accepted beat registers the write on the same edge: `o_wt_en`=1, `o_wt_data`=`i_data`, `o_wt_addr`=addr. The write is visible in the following cycle.
  - On each accepted beat, addr increments modulo 2^N (wraps from 2^N-1 to 0) and remaining decrements.
  - On a cycle with no accepted beat, `o_wt_en` is registered as 0.
  - When the last beat is accepted (remaining==1), go to DONE.
- DONE: lasts exactly one cycle, with `o_done`=1, then returns to IDLE.
  - `o_done` coincides with the final `o_wt_en` cycle of a clear or a non-empty load.
  - In DONE, `o_ready`=0 and new requests are ignored.
- `o_wt_en` is 0 in every cycle that is not a registered write cycle; it never stays high spuriously.
- Width rules:
  - The remaining counter is `REGS_WIDTH_ADDR`+1 bits.
  - The address counter is `REGS_WIDTH_ADDR` bits with natural wrap.
  - `i_load_len` values above 2^N are clamped to 2^N.

Decomposition:
- Shared package `regs_pkg`:
  - state enum (IDLE/CLEAR/LOAD/DONE);
  - `REGS_DEPTH`=2^`REGS_WIDTH_ADDR`;
  - zero-word constant.
- No sub-module is needed. The counters and FSM live in `regs_fill`.
- The testbench instantiates `regs_fill` feeding `regs` (`o_wt_*` to `i_wt_en`/`i_data`/`i_data_addr`) and checks contents through the register file's read port.

Test Plan (`REGS_WIDTH`=8, `REGS_WIDTH_ADDR`=4):
- Clear: pulse `i_clr` in IDLE.
  - Required: `o_wt_en` high for 16 consecutive cycles, addr 0..15, data 0x00.
  - `o_done` in the cycle of the addr-15 write.
  - All 16 entries read back 0x00.
- Load with stalls: base=3, len=4, data 0xA1,0xB2,0xC3,0xD4, with `i_valid` low for 2 cycles between beats 2 and 3.
  - Required: writes to 3,4,5,6 with the listed data.
  - `o_wt_en` low during the stall cycles.
  - `o_done` once; `o_busy` falls the cycle after `o_done`.
- Wrap-around: base=14, len=4, data 0x11..0x44.
  - Required: addresses 14,15,0,1; entries 2..13 unchanged.
- Zero length and full length:
  - len=0: `o_done` next cycle with no writes.
  - len=16 with base=5: all 16 entries written, addr sequence 5..15,0..4.
- Priority and ignore: assert `i_clr` and `i_load` together; later assert `i_load` during the clear.
  - Required: only the clear executes (16 zero writes); the mid-clear `i_load` has no effect.
- Reset mid-load: assert `i_rst` after 2 of 5 beats (base 0).
  - Required: entries 0,1 written; `o_wt_en`, `o_busy`, `o_ready` all 0 the cycle after reset.
  - No `o_done`; a new load works normally afterwards.
